// File: rtl/tmu_pkg.sv
// Shared types and constants for the TMU request front end.
// Coordinates default to 32 bits; fetch addresses step in 64-byte blocks.
package tmu_pkg;

  localparam int TMU_COORD_W   = 32;
  localparam int TMU_BLK_SHIFT = 6;

  typedef struct packed {
    logic [TMU_COORD_W-1:0] u;
    logic [TMU_COORD_W-1:0] v;
    logic [TMU_COORD_W-1:0] layer;
    logic [TMU_COORD_W-1:0] lod;
  } tmu_req_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    OUT
  } tmu_fetch_state_e;

endpackage

// File: rtl/tmu_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_mask at or after ptr, cyclically.
// N must be a power of two so the index sum wraps naturally.
module tmu_rr_arbiter
  import tmu_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]         req_mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_idx       = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = ptr + IW'(i);
      if (!grant_valid && req_mask[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/tmu_rr_fetch_pipe.sv
// Per-unit request FIFOs, round-robin pick, one decode fetch in flight at a time.
// Returns the lane addressed by u of the decoded block, tagged with its unit; full output backpressure.
module tmu_rr_fetch_pipe
  import tmu_pkg::*;
#(
  parameter int NUM_UNITS  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int COORD_W    = 32,
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int SAMP_W     = 128
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  input  logic [$clog2(NUM_UNITS)-1:0] req_unit,
  input  logic [COORD_W-1:0]           req_u,
  input  logic [COORD_W-1:0]           req_v,
  input  logic [COORD_W-1:0]           req_layer,
  input  logic [COORD_W-1:0]           req_lod,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            tex_base,
  output logic                         tex_req,
  input  logic                         tex_ready,
  output logic [ADDR_W-1:0]            tex_addr,
  input  logic                         tex_valid,
  input  logic [DATA_W-1:0]            tex_data,
  output logic                         samp_valid,
  input  logic                         samp_ready,
  output logic [SAMP_W-1:0]            samp_rgba,
  output logic [$clog2(NUM_UNITS)-1:0] samp_unit,
  output logic                         busy
);

  localparam int UW    = $clog2(NUM_UNITS);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int LANES = DATA_W / SAMP_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef struct packed {
    logic [COORD_W-1:0] u;
    logic [COORD_W-1:0] v;
    logic [COORD_W-1:0] layer;
    logic [COORD_W-1:0] lod;
  } req_t;

  req_t             r_fifo   [NUM_UNITS][FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr [NUM_UNITS];
  logic [PW-1:0]    r_rd_ptr [NUM_UNITS];
  logic [CW-1:0]    r_count  [NUM_UNITS];

  tmu_fetch_state_e r_state;
  logic [UW-1:0]    r_rr_ptr;
  logic [UW-1:0]    r_unit;
  req_t             r_hold;
  logic             r_tex_req;
  logic [ADDR_W-1:0] r_tex_addr;
  logic             r_samp_valid;
  logic [SAMP_W-1:0] r_samp_rgba;

  logic [NUM_UNITS-1:0] w_full;
  logic [NUM_UNITS-1:0] w_nonempty;
  logic [NUM_UNITS-1:0] w_push_vec;
  logic [NUM_UNITS-1:0] w_pop_vec;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_grant_vld;
  logic [UW-1:0]        w_grant_idx;
  req_t                 w_new;
  req_t                 w_head;
  logic [ADDR_W-1:0]    w_blk_off;
  logic [LW-1:0]        w_lane_idx;
  logic [SAMP_W-1:0]    w_lanes [LANES];

  always_comb begin
    w_full     = '0;
    w_nonempty = '0;
    w_push_vec = '0;
    w_pop_vec  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_full[i]     = (r_count[i] == CW'(FIFO_DEPTH));
      w_nonempty[i] = (r_count[i] != '0);
      w_push_vec[i] = w_push && (req_unit == UW'(i));
      w_pop_vec[i]  = w_pop && (w_grant_idx == UW'(i));
    end
  end

  // A full FIFO refuses pushes even when it is popped in the same cycle.
  assign req_ready = !w_full[req_unit];
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == IDLE) && w_grant_vld;
  assign w_new     = '{u: req_u, v: req_v, layer: req_layer, lod: req_lod};
  assign w_head    = r_fifo[w_grant_idx][r_rd_ptr[w_grant_idx]];
  assign w_blk_off = ADDR_W'({w_head.layer[7:0], w_head.v[11:0], w_head.u[11:0]}) << TMU_BLK_SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (w_push_vec[i]) r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
        if (w_pop_vec[i])  r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
        case ({w_push_vec[i], w_pop_vec[i]})
          2'b10:   r_count[i] <= r_count[i] + CW'(1);
          2'b01:   r_count[i] <= r_count[i] - CW'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[req_unit][r_wr_ptr[req_unit]] <= w_new;
  end

  tmu_rr_arbiter #(
    .N(NUM_UNITS)
  ) u_arb (
    .req_mask    (w_nonempty),
    .ptr         (r_rr_ptr),
    .grant_valid (w_grant_vld),
    .grant_idx   (w_grant_idx)
  );

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lanes[g] = tex_data[g*SAMP_W +: SAMP_W];
  end

  if (LANES > 1) begin : g_lane_sel
    assign w_lane_idx = r_hold.u[LW-1:0];
  end else begin : g_lane_zero
    assign w_lane_idx = '0;
  end

  // tex_valid outside WAIT falls through the case untouched, so stale returns are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_unit       <= '0;
      r_hold       <= '0;
      r_tex_req    <= 1'b0;
      r_tex_addr   <= '0;
      r_samp_valid <= 1'b0;
      r_samp_rgba  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_vld) begin
            r_hold     <= w_head;
            r_unit     <= w_grant_idx;
            r_tex_addr <= tex_base + w_blk_off;
            r_rr_ptr   <= w_grant_idx + UW'(1);
            r_tex_req  <= 1'b1;
            r_state    <= REQ;
          end
        end
        REQ: begin
          if (tex_ready) begin
            r_tex_req <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (tex_valid) begin
            r_samp_rgba  <= w_lanes[w_lane_idx];
            r_samp_valid <= 1'b1;
            r_state      <= OUT;
          end
        end
        OUT: begin
          if (samp_ready) begin
            r_samp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tex_req    = r_tex_req;
  assign tex_addr   = r_tex_addr;
  assign samp_valid = r_samp_valid;
  assign samp_rgba  = r_samp_rgba;
  assign samp_unit  = r_unit;
  assign busy       = (r_state != IDLE) || (|w_nonempty);

endmodule

// File: tb/tb_tmu_rr_fetch_pipe.sv
// Directed bench for tmu_rr_fetch_pipe with a per-unit scoreboard of expected fetch address and lane.
// The bench plays the decode unit; returned blocks encode their own address so each lane is recognisable.
module tb_tmu_rr_fetch_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [3:0]   req_unit;
  logic [31:0]  req_u, req_v, req_layer, req_lod;
  logic         req_ready;
  logic [63:0]  tex_base;
  logic         tex_req;
  logic         tex_ready;
  logic [63:0]  tex_addr;
  logic         tex_valid;
  logic [511:0] tex_data;
  logic         samp_valid;
  logic         samp_ready;
  logic [127:0] samp_rgba;
  logic [3:0]   samp_unit;
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  lane;
  } exp_t;

  exp_t sb [16][$];

  always #5 clk = ~clk;

  tmu_rr_fetch_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_unit   (req_unit),
    .req_u      (req_u),
    .req_v      (req_v),
    .req_layer  (req_layer),
    .req_lod    (req_lod),
    .req_ready  (req_ready),
    .tex_base   (tex_base),
    .tex_req    (tex_req),
    .tex_ready  (tex_ready),
    .tex_addr   (tex_addr),
    .tex_valid  (tex_valid),
    .tex_data   (tex_data),
    .samp_valid (samp_valid),
    .samp_ready (samp_ready),
    .samp_rgba  (samp_rgba),
    .samp_unit  (samp_unit),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [511:0] mk_data(input logic [63:0] a);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 4; k++) d[k*128 +: 128] = {a, 32'hCAFE_0000, 24'h0, 8'(k)};
    return d;
  endfunction

  // Called just after a falling edge; returns just after the next one.
  task automatic push(input int unit, input logic [31:0] u, input logic [31:0] v, input logic [31:0] layer);
    exp_t e;
    logic [31:0] blk;
    req_valid = 1'b1;
    req_unit  = 4'(unit);
    req_u     = u;
    req_v     = v;
    req_layer = layer;
    req_lod   = u ^ v;
    #1;
    chk("req_ready_push", req_ready, 1);
    blk    = {layer[7:0], v[11:0], u[11:0]};
    e.addr = tex_base + ({32'h0, blk} << 6);
    e.lane = u[1:0];
    sb[unit].push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_tex_req(input string tag);
    int n;
    n = 0;
    while (tex_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, tex_req, 1);
  endtask

  task automatic serve(input int unit, input int stall);
    exp_t         e;
    logic [511:0] d;
    logic [127:0] rg;
    wait_tex_req("tex_req_timeout");
    if (tex_req !== 1'b1) return;
    chk("scoreboard_has_entry", sb[unit].size() != 0, 1);
    if (sb[unit].size() == 0) return;
    e  = sb[unit].pop_front();
    d  = mk_data(e.addr);
    rg = d[e.lane*128 +: 128];
    chk("tex_addr", tex_addr, e.addr);
    tex_ready = 1'b1;
    @(negedge clk);
    tex_ready = 1'b0;
    chk("tex_req_after_accept", tex_req, 0);
    chk("no_early_samp", samp_valid, 0);
    tex_data  = d;
    tex_valid = 1'b1;
    @(negedge clk);
    tex_valid = 1'b0;
    tex_data  = '0;
    chk("samp_valid", samp_valid, 1);
    chk("samp_unit", samp_unit, unit);
    chk("samp_rgba", samp_rgba, rg);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_samp_valid", samp_valid, 1);
      chk("stall_samp_unit", samp_unit, unit);
      chk("stall_samp_rgba", samp_rgba, rg);
      chk("stall_tex_req", tex_req, 0);
    end
    samp_ready = 1'b1;
    @(negedge clk);
    samp_ready = 1'b0;
    chk("samp_valid_after_hs", samp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_unit   = '0;
    req_u      = '0;
    req_v      = '0;
    req_layer  = '0;
    req_lod    = '0;
    tex_base   = 64'h1000;
    tex_ready  = 1'b0;
    tex_valid  = 1'b0;
    tex_data   = '0;
    samp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_tex_req", tex_req, 0);
    chk("rst_samp_valid", samp_valid, 0);
    chk("rst_tex_addr", tex_addr, 0);
    chk("rst_samp_rgba", samp_rgba, 0);
    chk("rst_samp_unit", samp_unit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);

    // Single request: one-cycle latency to tex_req, block address 0x81140, lane 1.
    push(3, 32'h5, 32'h2, 32'h0);
    chk("single_tex_req_latency0", tex_req, 0);
    chk("single_busy", busy, 1);
    @(negedge clk);
    chk("single_tex_req_latency1", tex_req, 1);
    chk("single_addr_literal", tex_addr, 64'h81140);
    serve(3, 0);
    chk("single_idle_busy", busy, 0);

    // Fairness: unit 0's first entry is taken at once, the rest drain round-robin.
    tex_base = 64'h2000_0000;
    push(0, 32'h1, 32'h10, 32'h3);
    push(0, 32'h2, 32'h11, 32'h3);
    push(5, 32'h3, 32'h12, 32'h3);
    push(5, 32'h4, 32'h13, 32'h3);
    push(15, 32'h5, 32'h14, 32'h3);
    push(15, 32'h6, 32'h15, 32'h3);
    serve(0, 0);
    serve(5, 0);
    serve(15, 0);
    serve(0, 0);
    serve(5, 0);
    serve(15, 0);
    chk("fair_busy_done", busy, 0);

    // Full FIFO: park a fetch for unit 2, then fill unit 7.
    tex_base = 64'h40_0000;
    push(2, 32'h7, 32'h20, 32'h1);
    wait_tex_req("full_park_tex_req");
    push(7, 32'h100, 32'h30, 32'h2);
    push(7, 32'h101, 32'h31, 32'h2);
    push(7, 32'h102, 32'h32, 32'h2);
    push(7, 32'h103, 32'h33, 32'h2);
    req_unit = 4'd7;
    #1;
    chk("full_req_ready_u7", req_ready, 0);
    req_unit = 4'd6;
    #1;
    chk("full_req_ready_u6", req_ready, 1);
    req_valid = 1'b1;
    req_unit  = 4'd7;
    req_u     = 32'h1FF;
    @(negedge clk);
    req_valid = 1'b0;
    serve(2, 0);
    for (int i = 0; i < 4; i++) serve(7, 0);
    repeat (3) @(negedge clk);
    chk("full_dropped_tex_req", tex_req, 0);
    chk("full_dropped_busy", busy, 0);

    // Output backpressure with a second request waiting behind it.
    push(9, 32'h42, 32'h40, 32'h4);
    push(10, 32'h43, 32'h41, 32'h4);
    serve(9, 10);
    serve(10, 0);
    chk("bp_busy_done", busy, 0);

    // Spurious returns in IDLE and REQ.
    tex_data  = mk_data(64'hDEAD);
    tex_valid = 1'b1;
    @(negedge clk);
    tex_valid = 1'b0;
    chk("spur_idle_samp_valid", samp_valid, 0);
    chk("spur_idle_busy", busy, 0);
    push(1, 32'h9, 32'h50, 32'h5);
    wait_tex_req("spur_tex_req");
    tex_valid = 1'b1;
    @(negedge clk);
    tex_valid = 1'b0;
    chk("spur_req_samp_valid", samp_valid, 0);
    chk("spur_req_still_req", tex_req, 1);
    serve(1, 0);

    // Reset while in WAIT with three entries queued.
    push(4, 32'h10, 32'h60, 32'h6);
    push(4, 32'h11, 32'h61, 32'h6);
    push(4, 32'h12, 32'h62, 32'h6);
    push(12, 32'h13, 32'h63, 32'h6);
    wait_tex_req("mid_rst_tex_req");
    tex_ready = 1'b1;
    @(negedge clk);
    tex_ready = 1'b0;
    chk("mid_rst_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tex_req", tex_req, 0);
    chk("mid_rst_samp_valid", samp_valid, 0);
    chk("mid_rst_tex_addr", tex_addr, 0);
    chk("mid_rst_samp_rgba", samp_rgba, 0);
    chk("mid_rst_samp_unit", samp_unit, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 16; u++) sb[u].delete();
    @(negedge clk);
    tex_data  = mk_data(64'hBEEF);
    tex_valid = 1'b1;
    @(negedge clk);
    tex_valid = 1'b0;
    chk("post_rst_samp_valid", samp_valid, 0);
    chk("post_rst_tex_req", tex_req, 0);
    chk("post_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
